// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of a single-port registered ROM: one read per 3 cycles.
// Define ROM_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no read in flight; arbitrate on any high req
// S_ISSUE | ROM enabled with latched address; winner's gnt asserted
// S_WAIT  | ROM output arrives; captured into rsp_data on the exit edge
module rom_arbiter #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rsp_valid0,
    output logic          rsp_valid1,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          rom_enb,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   owner;
    logic   win1;
    logic   arb;

    assign arb = (state == S_IDLE) && (req0 || req1);

`ifdef ROM_ARB_RR_EN
    logic last1;

    // Reset value 1 makes requester 0 the favoured side of the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last1 <= 1'b1;
        else if (arb)
            last1 <= win1;
    end

    assign win1 = req1 && (!req0 || !last1);
`else
    assign win1 = req1 && !req0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (req0 || req1) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        rom_enb = 1'b0;
        busy    = 1'b0;
        unique case (state)
            S_ISSUE: begin
                gnt0    = !owner;
                gnt1    = owner;
                rom_enb = 1'b1;
                busy    = 1'b1;
            end
            S_WAIT:  busy = 1'b1;
            default: ;
        endcase
    end

    // rom_out is only meaningful in WAIT, so it is the only state that samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            owner      <= 1'b0;
            rsp_data   <= '0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
        end else begin
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            if (arb) begin
                rom_addr <= win1 ? addr1 : addr0;
                owner    <= win1;
            end
            if (state == S_WAIT) begin
                rsp_data   <= rom_out;
                rsp_valid0 <= !owner;
                rsp_valid1 <= owner;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Tie expectations follow ROM_ARB_RR_EN when it is defined for the build.
module tb_rom_arbiter;
    localparam int AW = 3;
    localparam int DW = 8;
`ifdef ROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          gnt0, gnt1, rsp_valid0, rsp_valid1, busy, rom_enb;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_out = '0;
    logic [DW-1:0] rom [8];

    rom_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_data(rsp_data), .busy(busy), .rom_enb(rom_enb), .rom_addr(rom_addr),
        .rom_out(rom_out)
    );

    always #5 clk = ~clk;

    // Registered ROM; garbage whenever not enabled so stray sampling shows up.
    always @(posedge clk) rom_out <= rom_enb ? rom[rom_addr] : 8'($urandom);

    int checks = 0;
    int errors = 0;
    int s = 0;
    int gnt_step, gnt_who, rsp_step, free_at, last_srv;
    logic [DW-1:0] rsp_val, last_data;
    logic [AW-1:0] exp_addr;
    bit hold0 = 1'b0, hold1 = 1'b0;
    int gseq[$];

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0b expected=%0b", tag, s, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, s, obs, exp);
        end
    endtask

    task automatic model_reset();
        gnt_step  = -100;
        gnt_who   = 0;
        rsp_step  = -100;
        free_at   = 0;
        last_srv  = 1;
        last_data = '0;
        exp_addr  = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk_b({tag, "_gnt0"}, gnt0, 1'b0);
        chk_b({tag, "_gnt1"}, gnt1, 1'b0);
        chk_b({tag, "_rv0"}, rsp_valid0, 1'b0);
        chk_b({tag, "_rv1"}, rsp_valid1, 1'b0);
        chk_v({tag, "_data"}, rsp_data, 8'h00);
        chk_b({tag, "_enb"}, rom_enb, 1'b0);
        chk_v({tag, "_addr"}, 8'(rom_addr), 8'h00);
        chk_b({tag, "_busy"}, busy, 1'b0);
    endtask

    // One clock: predict this edge's arbitration, then compare all outputs just after it.
    task automatic tick();
        int w;
        logic [AW-1:0] a;
        w = -1;
        if (rst_n && s >= free_at && (req0 || req1)) begin
            if (req0 && req1) w = (RR && last_srv == 0) ? 1 : 0;
            else              w = req0 ? 0 : 1;
            a        = (w == 1) ? addr1 : addr0;
            gnt_step = s;
            gnt_who  = w;
            rsp_step = s + 2;
            rsp_val  = rom[a];
            free_at  = s + 3;
            last_srv = w;
            exp_addr = a;
        end
        @(posedge clk);
        #1;
        if (s == rsp_step) last_data = rsp_val;
        chk_b("gnt0", gnt0, s == gnt_step && gnt_who == 0);
        chk_b("gnt1", gnt1, s == gnt_step && gnt_who == 1);
        chk_b("rom_enb", rom_enb, s == gnt_step);
        chk_b("busy", busy, s == gnt_step || s == gnt_step + 1);
        chk_b("rsp_valid0", rsp_valid0, s == rsp_step && gnt_who == 0);
        chk_b("rsp_valid1", rsp_valid1, s == rsp_step && gnt_who == 1);
        chk_v("rsp_data", rsp_data, last_data);
        if (s == gnt_step || s == gnt_step + 1) chk_v("rom_addr", 8'(rom_addr), 8'(exp_addr));
        chk_b("gnt_excl", gnt0 & gnt1, 1'b0);
        chk_b("rsp_excl", rsp_valid0 & rsp_valid1, 1'b0);
        if (gnt0) gseq.push_back(0);
        if (gnt1) gseq.push_back(1);
        if (w == 0 && !hold0) req0 = 1'b0;
        if (w == 1 && !hold1) req1 = 1'b0;
        s++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_zero("rst");
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rom[0] = 8'h01; rom[1] = 8'hAA; rom[2] = 8'h54; rom[3] = 8'hFA;
        rom[4] = 8'hE5; rom[5] = 8'h98; rom[6] = 8'h56; rom[7] = 8'h34;
        model_reset();
        #1;
        chk_zero("por");
        tick();
        tick();
        rst_n = 1'b1;

        // Single read at address 3
        req0 = 1'b1; addr0 = 3'd3;
        tick();
        chk_b("t27_gnt0", gnt0, 1'b1);
        tick();
        chk_b("t27_enb_wait", rom_enb, 1'b0);
        tick();
        chk_b("t27_rv0", rsp_valid0, 1'b1);
        chk_v("t27_data", rsp_data, 8'hFA);
        tick();

        // Address changed during ISSUE: latched address wins
        req0 = 1'b1; addr0 = 3'd5;
        tick();
        addr0 = 3'd6;
        tick();
        chk_b("t31_busy_wait", busy, 1'b1);
        tick();
        chk_v("t31_data", rsp_data, 8'h98);
        chk_b("t31_busy_idle", busy, 1'b0);
        repeat (2) tick();

        // Simultaneous requests, neither reasserted
        do_reset();
        req0 = 1'b1; addr0 = 3'd1; req1 = 1'b1; addr1 = 3'd4;
        tick();
        chk_b("t28_first_gnt0", gnt0, 1'b1);
        repeat (2) tick();
        chk_b("t28_rv0", rsp_valid0, 1'b1);
        chk_v("t28_data0", rsp_data, 8'hAA);
        tick();
        chk_b("t28_second_gnt1", gnt1, 1'b1);
        repeat (2) tick();
        chk_b("t28_rv1", rsp_valid1, 1'b1);
        chk_v("t28_data1", rsp_data, 8'hE5);
        repeat (2) tick();

        // Simultaneous requests with req0 reasserted after its grant
        do_reset();
        hold0 = 1'b1;
        req0 = 1'b1; addr0 = 3'd1; req1 = 1'b1; addr1 = 3'd4;
        tick();
        chk_b("t28b_gnt0", gnt0, 1'b1);
        repeat (2) tick();
        tick();
        chk_b("t28b_again_gnt0", gnt0, !RR);
        chk_b("t28b_again_gnt1", gnt1, RR);
        hold0 = 1'b0;
        repeat (9) tick();

        // Both held for 12 cycles
        do_reset();
        hold0 = 1'b1; hold1 = 1'b1;
        req0 = 1'b1; addr0 = 3'd0; req1 = 1'b1; addr1 = 3'd7;
        gseq.delete();
        repeat (12) tick();
        chk_v("t29_ngrants", 8'(gseq.size()), 8'd4);
        for (int k = 0; k < 4 && k < gseq.size(); k++)
            chk_b("t29_order", gseq[k][0], RR ? k[0] : 1'b0);
        hold0 = 1'b0; hold1 = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();

        // Reset during WAIT abandons the read; the first post-reset edge accepts a new one
        req0 = 1'b1; addr0 = 3'd7;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_zero("t30_rst");
        tick();
        rst_n = 1'b1;
        req0 = 1'b1; addr0 = 3'd2;
        tick();
        chk_b("t30_gnt0", gnt0, 1'b1);
        repeat (2) tick();
        chk_b("t30_rv0", rsp_valid0, 1'b1);
        chk_v("t30_data", rsp_data, 8'h54);
        tick();

        // Random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            if (!req0) begin
                addr0 = 3'($urandom);
                if ($urandom_range(2) == 0) req0 = 1'b1;
            end
            if (!req1) begin
                addr1 = 3'($urandom);
                if ($urandom_range(2) == 0) req1 = 1'b1;
            end
            if ($urandom_range(80) == 0) do_reset();
            else tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
